// File: rtl/trace_buffer_if.sv
// Trace buffer bus: capture inputs, trigger controls and readout port.
// The master side (test harness / debug host) drives samples and controls,
// the slave side (trace_buffer) returns readout data and capture status.
interface trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  // capture side
  logic              iValid;
  logic [DATA_W-1:0] iPC;
  logic [31:0]       iInstr;

  // arming and trigger control
  logic              iArm;
  logic              iTrigEn;
  logic [DATA_W-1:0] iTrigPC;
  logic              iTrigForce;

  // readout and status
  logic [AW-1:0]     iRdIdx;
  logic [DATA_W-1:0] oRdPC;
  logic [31:0]       oRdInstr;
  logic [1:0]        oState;
  logic              oDone;
  logic [AW:0]       oCount;
  logic [AW-1:0]     oTrigPos;

  modport master (
    output iValid, iPC, iInstr, iArm, iTrigEn, iTrigPC, iTrigForce, iRdIdx,
    input  oRdPC, oRdInstr, oState, oDone, oCount, oTrigPos
  );

  modport slave (
    input  iValid, iPC, iInstr, iArm, iTrigEn, iTrigPC, iTrigForce, iRdIdx,
    output oRdPC, oRdInstr, oState, oDone, oCount, oTrigPos
  );
endinterface

// File: rtl/trace_buffer.sv
// Circular PC/instruction trace buffer with pre/post trigger capture.
// Samples stream into a ring while PRE; a PC match or forced trigger records
// the trigger slot and then POST_TRIG more samples are kept before freezing.
// Readout is indexed oldest-first with one cycle of registered latency.
module trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  trace_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_W + 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] AW_ONE     = AW'(1);
  localparam logic [AW-1:0] POST_INIT  = AW'(POST_TRIG);

  // control state
  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] wp_q,        wp_d;
  logic [AW:0]   count_q,     count_d;
  logic [AW-1:0] post_q,      post_d;
  logic [AW-1:0] trig_slot_q, trig_slot_d;
  logic          rd_ok_q,     rd_ok_d;

  // sample storage; never reset, stale words are masked by the count
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word_q;

  logic          capturing;
  logic          trig_hit;
  logic          wr_en;
  logic [AW-1:0] start_slot;
  logic [AW-1:0] rd_slot;

  // capture qualifiers: arming always wins and suppresses the write
  always_comb begin
    capturing  = (state_q == ST_PRE) || (state_q == ST_POST);
    trig_hit   = bus.iValid &
                 (bus.iTrigForce | (bus.iTrigEn & (bus.iPC == bus.iTrigPC)));
    wr_en      = capturing & bus.iValid & ~bus.iArm;
    // once the ring has wrapped the oldest sample sits at the write pointer
    start_slot = (count_q == COUNT_FULL) ? wp_q : '0;
    rd_slot    = start_slot + bus.iRdIdx;
    rd_ok_d    = ({1'b0, bus.iRdIdx} < count_q);
  end

  // next-state logic for the capture FSM, pointers and counters
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    count_d     = count_q;
    post_d      = post_q;
    trig_slot_d = trig_slot_q;

    if (bus.iArm) begin
      state_d     = ST_PRE;
      wp_d        = '0;
      count_d     = '0;
      post_d      = '0;
      trig_slot_d = '0;
    end else begin
      if (wr_en) begin
        wp_d = wp_q + AW_ONE;
        if (count_q != COUNT_FULL) begin
          count_d = count_q + COUNT_ONE;
        end
      end

      case (state_q)
        ST_PRE: begin
          if (trig_hit) begin
            // the triggering sample itself lands in the current write slot
            trig_slot_d = wp_q;
            if (POST_TRIG == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              post_d  = POST_INIT;
            end
          end
        end
        ST_POST: begin
          if (bus.iValid) begin
            post_d = post_q - AW_ONE;
            if (post_q == AW_ONE) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // control registers with asynchronous active-low reset
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      count_q     <= '0;
      post_q      <= '0;
      trig_slot_q <= '0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      count_q     <= count_d;
      post_q      <= post_d;
      trig_slot_q <= trig_slot_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  // sample RAM: write port from capture, registered read port for readout
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      mem[wp_q] <= {bus.iPC, bus.iInstr};
    end
    rd_word_q <= mem[rd_slot];
  end

  // readout is zeroed when the index is past the held samples or after reset
  assign bus.oRdPC    = rd_ok_q ? rd_word_q[MW-1:32] : '0;
  assign bus.oRdInstr = rd_ok_q ? rd_word_q[31:0]    : '0;

  assign bus.oState   = state_q;
  assign bus.oDone    = (state_q == ST_DONE);
  assign bus.oCount   = count_q;
  assign bus.oTrigPos = ((state_q == ST_POST) || (state_q == ST_DONE))
                        ? (trig_slot_q - start_slot) : '0;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: scenario table plus readout vector table,
// with hand-written sequences for reset-during-capture and arm priority.
module tb_trace_buffer;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;
  localparam int AW        = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  trace_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  trace_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .POST_TRIG(POST_TRIG)
  ) dut (
    .iCLK (clk),
    .iRSTn(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    bit force_trig;
    bit gaps;
    int cycles;
    int count;
    int trigpos;
    int rd_scen;
  } scen_t;

  typedef struct {
    int          scen;
    logic [3:0]  idx;
    logic [31:0] pc;
    logic [31:0] instr;
  } rd_vec_t;

  scen_t   scen_tab [3];
  rd_vec_t rd_tab   [10];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic idle_inputs();
    bus.iValid     = 1'b0;
    bus.iPC        = '0;
    bus.iInstr     = '0;
    bus.iArm       = 1'b0;
    bus.iTrigEn    = 1'b0;
    bus.iTrigPC    = '0;
    bus.iTrigForce = 1'b0;
    bus.iRdIdx     = '0;
  endtask

  // one arm cycle carrying a PC that would match, which must be ignored
  task automatic arm();
    bus.iArm   = 1'b1;
    bus.iValid = 1'b1;
    bus.iPC    = 32'h40;
    bus.iInstr = 32'hBAD0_0000;
    tick();
    bus.iArm   = 1'b0;
    bus.iValid = 1'b0;
  endtask

  // arm and stream samples PC=4k until oDone or the cycle budget runs out
  task automatic run_capture(input bit force_trig, input bit gaps, output int cycles);
    int k;
    int trig_k;
    bit post;
    bit tog;
    bit v;
    k       = 0;
    post    = 1'b0;
    tog     = 1'b0;
    trig_k  = force_trig ? 0 : 16;
    cycles  = 0;
    bus.iTrigEn = 1'b1;
    bus.iTrigPC = 32'h40;
    arm();
    while (cycles < 200) begin
      v = 1'b1;
      if (post && gaps) begin
        v   = tog;
        tog = ~tog;
      end
      bus.iValid     = v;
      bus.iPC        = 32'(4 * k);
      bus.iInstr     = instr_of(k);
      bus.iTrigForce = force_trig && (k == 0) && v;
      tick();
      cycles++;
      if (v) begin
        if (k == trig_k) post = 1'b1;
        k++;
      end
      if (bus.oDone) break;
    end
    bus.iValid     = 1'b0;
    bus.iTrigForce = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] idx,
                            input logic [31:0] pc, input logic [31:0] instr);
    bus.iRdIdx = idx;
    tick();
    check($sformatf("%s rd_pc[%0d]", tag, idx), 64'(bus.oRdPC), 64'(pc));
    check($sformatf("%s rd_instr[%0d]", tag, idx), 64'(bus.oRdInstr), 64'(instr));
  endtask

  // apply the readout table for one scenario while junk samples keep arriving
  task automatic readout_table(input string tag, input int rd_scen);
    for (int i = 0; i < 10; i++) begin
      if (rd_tab[i].scen == rd_scen) begin
        bus.iValid = 1'b1;
        bus.iPC    = 32'hDEAD_0000 + 32'(i);
        bus.iInstr = 32'hFEED_0000 + 32'(i);
        read_check(tag, rd_tab[i].idx, rd_tab[i].pc, rd_tab[i].instr);
      end
    end
    bus.iValid = 1'b0;
  endtask

  task automatic check_done(input string tag, input scen_t sc, input int cycles);
    check({tag, " cycles"},  64'(cycles),        64'(sc.cycles));
    check({tag, " state"},   64'(bus.oState),    64'(3));
    check({tag, " done"},    64'(bus.oDone),     64'(1));
    check({tag, " count"},   64'(bus.oCount),    64'(sc.count));
    check({tag, " trigpos"}, 64'(bus.oTrigPos),  64'(sc.trigpos));
  endtask

  initial begin
    int cyc;

    // full continuous run, forced trigger on sample 0, and gapped post phase
    scen_tab[0] = '{1'b0, 1'b0, 25, 16, 7, 0};
    scen_tab[1] = '{1'b1, 1'b0,  9,  9, 0, 1};
    scen_tab[2] = '{1'b0, 1'b1, 33, 16, 7, 0};

    // after the PC-match run: ring holds samples 9..24, oldest first
    rd_tab[0] = '{0, 4'd0,  32'h24, 32'hC0DE_0009};
    rd_tab[1] = '{0, 4'd5,  32'h38, 32'hC0DE_000E};
    rd_tab[2] = '{0, 4'd7,  32'h40, 32'hC0DE_0010};
    rd_tab[3] = '{0, 4'd8,  32'h44, 32'hC0DE_0011};
    rd_tab[4] = '{0, 4'd15, 32'h60, 32'hC0DE_0018};
    // after the forced run: samples 0..8, indices 9+ read as zero
    rd_tab[5] = '{1, 4'd0,  32'h00, 32'hC0DE_0000};
    rd_tab[6] = '{1, 4'd4,  32'h10, 32'hC0DE_0004};
    rd_tab[7] = '{1, 4'd8,  32'h20, 32'hC0DE_0008};
    rd_tab[8] = '{1, 4'd9,  32'h00, 32'h0000_0000};
    rd_tab[9] = '{1, 4'd15, 32'h00, 32'h0000_0000};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle after reset: nothing captured, readout zero at every index
    for (int i = 0; i < 20; i++) begin
      bus.iValid = 1'b1;
      bus.iPC    = 32'(4 * i);
      bus.iRdIdx = 4'(i);
      tick();
      check($sformatf("idle%0d status", i),
            {56'd0, bus.oState, bus.oDone, bus.oCount},
            64'd0);
      check($sformatf("idle%0d rd", i), {bus.oRdPC, bus.oRdInstr}, 64'd0);
    end
    bus.iValid = 1'b0;

    // table-driven capture scenarios
    for (int s = 0; s < 3; s++) begin
      run_capture(scen_tab[s].force_trig, scen_tab[s].gaps, cyc);
      check_done($sformatf("scen%0d", s), scen_tab[s], cyc);
      readout_table($sformatf("scen%0d", s), scen_tab[s].rd_scen);
      check($sformatf("scen%0d count_after_rd", s), 64'(bus.oCount), 64'(scen_tab[s].count));
    end

    // reset pulse in the middle of POST aborts capture immediately
    bus.iTrigEn = 1'b1;
    bus.iTrigPC = 32'h40;
    arm();
    for (int k = 0; k < 20; k++) begin
      bus.iValid = 1'b1;
      bus.iPC    = 32'(4 * k);
      bus.iInstr = instr_of(k);
      tick();
    end
    bus.iValid = 1'b0;
    check("midpost state", 64'(bus.oState), 64'(2));
    rst_n = 1'b0;
    #1;
    check("rst state", 64'(bus.oState), 64'(0));
    check("rst count", 64'(bus.oCount), 64'(0));
    check("rst rd",    {bus.oRdPC, bus.oRdInstr}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_capture(1'b0, 1'b0, cyc);
    check_done("rerun", scen_tab[0], cyc);
    readout_table("rerun", 0);

    // arm coinciding with a PC match in PRE: restart wins, nothing written
    bus.iTrigEn = 1'b1;
    bus.iTrigPC = 32'h40;
    arm();
    for (int k = 0; k < 3; k++) begin
      bus.iValid = 1'b1;
      bus.iPC    = 32'(4 * k);
      bus.iInstr = instr_of(k);
      tick();
    end
    check("pre count", 64'(bus.oCount), 64'(3));
    bus.iArm   = 1'b1;
    bus.iValid = 1'b1;
    bus.iPC    = 32'h40;
    bus.iInstr = instr_of(16);
    tick();
    bus.iArm   = 1'b0;
    check("armhit state",   64'(bus.oState),   64'(1));
    check("armhit count",   64'(bus.oCount),   64'(0));
    check("armhit trigpos", 64'(bus.oTrigPos), 64'(0));
    bus.iPC    = 32'h44;
    bus.iInstr = instr_of(17);
    tick();
    bus.iValid = 1'b0;
    check("after state", 64'(bus.oState), 64'(1));
    check("after count", 64'(bus.oCount), 64'(1));
    read_check("armhit", 4'd0, 32'h44, instr_of(17));
    read_check("armhit", 4'd1, 32'h00, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32: PC sample width.
REQ-002 Parameter DEPTH, default 16: sample slots; power of 2, >=4; AW = log2(DEPTH).
REQ-003 Parameter POST_TRIG, default 8: samples captured after trigger sample; range 0..DEPTH-1.
REQ-004 The module SHALL have one clock, iCLK, and an asynchronous, active-low reset, iRSTn.
REQ-005 Ports:
- iCLK  in  1  clock
- iRSTn  in  1  async active-low reset
- iValid  in  1  sample qualifier
- iPC  in  DATA_W  PC sample
- iInstr  in  32  instruction sample
- iArm  in  1  start/restart capture (level, sampled per cycle)
- iTrigEn  in  1  enable PC-match trigger
- iTrigPC  in  DATA_W  trigger PC value
- iTrigForce  in  1  unconditional trigger
- iRdIdx  in  AW  readout index, 0 = oldest
- oRdPC  out  DATA_W  readout PC
- oRdInstr  out  32  readout instruction
- oState  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE
- oDone  out  1  high in DONE
- oCount  out  AW+1  valid samples held
- oTrigPos  out  AW  readout index of trigger sample

Function
REQ-006 FSM SHALL be IDLE, PRE, POST, DONE; iArm=1 from any state -> PRE next cycle; write pointer, count and post counter cleared.
REQ-007 A sample SHALL be written only in PRE or POST with iValid=1: mem[wp] <= {iPC,iInstr}; wp += 1 mod DEPTH; oCount += 1, saturating at DEPTH.
REQ-008 Trigger SHALL be iValid & (iTrigForce | (iTrigEn & iPC==iTrigPC)), evaluated only in PRE; the triggering sample is written and its slot recorded.
REQ-009 PRE + trigger: POST_TRIG>0 -> POST with post counter = POST_TRIG; POST_TRIG=0 -> DONE.
REQ-010 In POST, each written sample decrements the post counter; the write taking it to 0 -> DONE in the same cycle; cycles with iValid=0 write nothing and do not decrement.
REQ-011 IDLE and DONE SHALL write nothing; trigger ignored outside PRE.
REQ-012 iArm SHALL have priority over a simultaneous trigger or sample; that cycle writes nothing.
REQ-013 Trigger before DEPTH pre-samples is legal; pre-trigger history is shorter.
REQ-014 Oldest slot start = wp if oCount==DEPTH, else 0; oTrigPos = (trig_slot - start) mod DEPTH, valid in POST/DONE, 0 otherwise.
REQ-015 oRdPC/oRdInstr SHALL be registered, 1-cycle latency, from mem[(start + iRdIdx) mod DEPTH]; iRdIdx >= oCount -> both 0.
REQ-016 Readout SHALL be valid in every state; reading does not alter capture.
REQ-017 oDone = (oState==3), combinational from state register.

Reset
REQ-018 iRSTn=0 SHALL asynchronously force IDLE, wp=0, oCount=0, post counter=0, trig slot=0, oRdPC=0, oRdInstr=0, oDone=0, oTrigPos=0.
REQ-019 Memory array SHALL not be reset; stale contents unreadable since oCount=0.
REQ-020 Reset mid-PRE/POST aborts capture; a later iArm SHALL behave as from power-up.

Verification (DEPTH=16, POST_TRIG=8, sample k PC=4k)
REQ-021 Reset release, no arm -> oState=0, oCount=0, oRdPC=0, oRdInstr=0, oDone=0 for 20 cycles.
REQ-022 Arm, iValid=1 continuous, iTrigEn=1, iTrigPC=0x40 -> trigger at sample 16, DONE after sample 24; oCount=16, oTrigPos=7, idx0 -> 0x24, idx15 -> 0x60.
REQ-023 Arm, iTrigForce=1 on sample 0 -> DONE after sample 8; oCount=9, oTrigPos=0, idx8 -> 0x20, idx9 -> 0.
REQ-024 Scenario REQ-022 with iValid low every other post-trigger cycle -> DONE delayed by exactly the gap count; captured data identical.
REQ-025 iRSTn low 1 cycle in POST -> IDLE, oCount=0 immediately; re-arm and rerun of REQ-022 yields identical results.
REQ-026 In PRE, iArm=1 same cycle as PC match -> state stays PRE, oCount=0, sample not written, no trigger recorded.
